// File: rtl/half_softmax_sched_pkg.sv
// Shared types and helpers for the half-precision softmax scheduler.
//   half_t    : one IEEE-754 binary16 value
//   HALF_ZERO : +0.0 in binary16, used as the reset value of vector registers
//   rr_index  : cyclic index helper for the round-robin arbiter
package half_softmax_sched_pkg;

    typedef logic [15:0] half_t;

    localparam half_t HALF_ZERO = 16'h0000;

    // Position 'off' steps after 'base' on a ring of 'n' requesters.
    function automatic int rr_index(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/half_softmax_sched_if.sv
// Bundle of the requester, softmax-datapath and response signals of the
// scheduler.
//   req_valid / req_vector / req_ready : requester handshake (one-hot ready)
//   sm_start / sm_vector_a             : issue toward half_softmax_v
//   sm_done / sm_vector_c              : completion from half_softmax_v
//   rsp_valid / rsp_id / rsp_vector    : routed result, no backpressure
// slave  : the scheduler's view
// master : the environment's view (requesters + datapath + result sink)
interface half_softmax_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    import half_softmax_sched_pkg::*;

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]                   req_valid;
    half_t [NREQ-1:0][WIDTH-1:0]       req_vector;
    logic [NREQ-1:0]                   req_ready;
    logic                              sm_start;
    half_t [WIDTH-1:0]                 sm_vector_a;
    logic                              sm_done;
    half_t [WIDTH-1:0]                 sm_vector_c;
    logic                              rsp_valid;
    logic [IDW-1:0]                    rsp_id;
    half_t [WIDTH-1:0]                 rsp_vector;

    modport slave (
        input  req_valid, req_vector, sm_done, sm_vector_c,
        output req_ready, sm_start, sm_vector_a, rsp_valid, rsp_id, rsp_vector
    );

    modport master (
        output req_valid, req_vector, sm_done, sm_vector_c,
        input  req_ready, sm_start, sm_vector_a, rsp_valid, rsp_id, rsp_vector
    );

endinterface

// File: rtl/half_softmax_sched_tag_fifo.sv
// Synchronous tag FIFO recording which requester owns each issued vector.
// Ports:
//   clk, rstn  : clock, synchronous active-low reset
//   push, push_data : write a tag
//   pop, pop_data   : read the oldest tag (pop_data valid whenever pop is legal)
//   full, empty, count : occupancy status, count in 0..DEPTH
// Push and pop together are accepted even when full or empty; when empty the
// pushed tag is forwarded straight to pop_data.
module half_softmax_sched_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s, do_pop_s;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == {CW{1'b0}});
    assign count = count_q;

    // Oldest entry, or the incoming tag when the FIFO is empty.
    assign pop_data = empty ? push_data : mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_push_s = push & (~full | pop);
        do_pop_s  = pop & (~empty | push);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
    end

    // FIFO state registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DW{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/half_softmax_sched.sv
// Shares one half_softmax_v pipeline between NREQ requesters.
// Round-robin arbitration issues at most one vector per cycle, outstanding
// vectors are capped at MAX_INFLIGHT, and each issue's requester id is kept in
// an in-order tag FIFO so results are routed back to their owner.
// Ports:
//   clk, rstn  : clock, synchronous active-low reset
//   enable     : 0 blocks new grants; in-flight work still completes
//   bus        : requester handshake, datapath issue/completion, response
//   inflight   : issued-but-not-completed count
//   idle       : nothing outstanding, nothing being issued or returned
//   err_orphan : sticky, a completion arrived with no owner on record
module half_softmax_sched
    import half_softmax_sched_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int WIDTH        = 8,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enable,
    half_softmax_sched_if.slave           bus,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    output logic                          idle,
    output logic                          err_orphan
);

    localparam int IDW = $clog2(NREQ);
    localparam int CNTW = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [CNTW:0] MAX_CREDIT = (CNTW + 1)'(MAX_INFLIGHT);

    typedef half_t [WIDTH-1:0] vec_t;

    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            sm_start_q, sm_start_d;
    vec_t            sm_vec_a_q, sm_vec_a_d;
    logic [IDW-1:0]  tag_q, tag_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    vec_t            rsp_vec_q, rsp_vec_d;
    logic            err_orphan_q, err_orphan_d;
    logic            idle_q, idle_d;

    logic [CNTW-1:0] fifo_count_s;
    logic            fifo_full_s, fifo_empty_s;
    logic [IDW-1:0]  fifo_pop_data_s;
    logic            push_s, pop_s, orphan_s;
    logic [CNTW:0]   pending_s;
    logic            credit_ok_s;
    logic            hs_s;
    logic [IDW-1:0]  grant_idx_s;
    logic [NREQ-1:0] grant_s;
    logic [CNTW-1:0] inflight_next_s;

    // Credit includes the issue sitting in the sm_start register, which is
    // not yet in the tag FIFO; this keeps inflight from ever passing the cap.
    always_comb begin
        pending_s   = {1'b0, fifo_count_s} + {{CNTW{1'b0}}, sm_start_q};
        credit_ok_s = (pending_s < MAX_CREDIT);
    end

    // Round-robin arbiter: first valid requester at or after rr_ptr.
    always_comb begin
        hs_s        = 1'b0;
        grant_idx_s = {IDW{1'b0}};
        grant_s     = {NREQ{1'b0}};
        if (rstn && enable && credit_ok_s) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!hs_s && bus.req_valid[rr_index(int'(rr_ptr_q), i, NREQ)]) begin
                    hs_s        = 1'b1;
                    grant_idx_s = IDW'(rr_index(int'(rr_ptr_q), i, NREQ));
                end
            end
        end else begin
            hs_s = 1'b0;
        end
        if (hs_s) begin
            grant_s[grant_idx_s] = 1'b1;
        end else begin
            grant_s = {NREQ{1'b0}};
        end
    end

    // Issue register next-state: capture the granted vector and its owner.
    always_comb begin
        sm_start_d = hs_s;
        sm_vec_a_d = sm_vec_a_q;
        tag_d      = tag_q;
        rr_ptr_d   = rr_ptr_q;
        if (hs_s) begin
            sm_vec_a_d = bus.req_vector[grant_idx_s];
            tag_d      = grant_idx_s;
            rr_ptr_d   = IDW'(rr_index(int'(grant_idx_s), 1, NREQ));
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Completion handling. A done with an empty FIFO is only legal when the
    // matching tag is being pushed in the same cycle (forwarded by the FIFO).
    always_comb begin
        push_s       = sm_start_q & (~fifo_full_s | bus.sm_done);
        pop_s        = bus.sm_done & (~fifo_empty_s | push_s);
        orphan_s     = bus.sm_done & fifo_empty_s & ~push_s;
        rsp_valid_d  = pop_s;
        rsp_id_d     = rsp_id_q;
        rsp_vec_d    = rsp_vec_q;
        if (pop_s) begin
            rsp_id_d  = fifo_pop_data_s;
            rsp_vec_d = bus.sm_vector_c;
        end else begin
            rsp_id_d  = rsp_id_q;
            rsp_vec_d = rsp_vec_q;
        end
        err_orphan_d    = err_orphan_q | orphan_s;
        inflight_next_s = fifo_count_s + CNTW'(push_s) - CNTW'(pop_s);
        idle_d          = (inflight_next_s == {CNTW{1'b0}}) & ~sm_start_d & ~rsp_valid_d;
    end

    // Issue, response and status registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr_q     <= {IDW{1'b0}};
            sm_start_q   <= 1'b0;
            sm_vec_a_q   <= {WIDTH{HALF_ZERO}};
            tag_q        <= {IDW{1'b0}};
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= {IDW{1'b0}};
            rsp_vec_q    <= {WIDTH{HALF_ZERO}};
            err_orphan_q <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            sm_start_q   <= sm_start_d;
            sm_vec_a_q   <= sm_vec_a_d;
            tag_q        <= tag_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_vec_q    <= rsp_vec_d;
            err_orphan_q <= err_orphan_d;
            idle_q       <= idle_d;
        end
    end

    half_softmax_sched_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .DW    (IDW)
    ) u_tag_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push_s),
        .push_data (tag_q),
        .pop       (pop_s),
        .pop_data  (fifo_pop_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign bus.req_ready   = grant_s;
    assign bus.sm_start    = sm_start_q;
    assign bus.sm_vector_a = sm_vec_a_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_vector  = rsp_vec_q;
    assign inflight        = fifo_count_s;
    assign idle            = idle_q;
    assign err_orphan      = err_orphan_q;

endmodule
